// File: rtl/dma_pkg.sv
// dma_pkg: register offsets, CTRL bit indices, FSM states and SoC decode window for the DMA
package dma_pkg;
  localparam logic [1:0] dma_src_off = 2'd0;
  localparam logic [1:0] dma_dst_off = 2'd1;
  localparam logic [1:0] dma_len_off = 2'd2;
  localparam logic [1:0] dma_ctrl_off = 2'd3;
  localparam int ctrl_start = 0;
  localparam int ctrl_busy = 1;
  localparam int ctrl_done = 2;
  localparam int ctrl_irq_en = 3;
  localparam logic [31:0] dma_base_addr = 32'h3000_0000;
  localparam logic [31:0] dma_top_addr = 32'h3000_000f;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} dma_state_t;
endpackage

// File: rtl/dma.sv
// dma: word-copy engine with a register port and one-outstanding master port; DMA_IRQ_EN adds the irq
module dma
  import dma_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        dma_valid,
  input  logic        dma_instr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_wstrb,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        dmem_valid,
  output logic        dmem_instr,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        dma_irq
);
  dma_state_t state, state_n;
  logic [31:0] src, dst, len, cur_src, cur_dst, remaining, data;
  logic done, irq_en, ack, rd;
  logic [1:0] rsel;
  logic wr, busy, start, complete;
  logic unused_bits;
  assign unused_bits = ^{dma_instr, dma_addr[31:4], dma_addr[1:0]};
  assign wr = dma_valid && dma_wstrb == 4'hf;
  assign busy = state != IDLE;
  assign start = wr && dma_addr[3:2] == dma_ctrl_off && dma_wdata[ctrl_start] && !busy;
  // an empty transfer finishes on the start edge itself
  assign complete = (start && len == '0) || (state == WR_WAIT && dmem_ready && remaining == 32'd1);
  always_ff @(posedge clock) begin
    if (reset) begin
      src <= '0;
      dst <= '0;
      len <= '0;
      done <= 1'b0;
      irq_en <= 1'b0;
      ack <= 1'b0;
      rd <= 1'b0;
      rsel <= '0;
    end else begin
      ack <= dma_valid;
      rd <= dma_valid && dma_wstrb == 4'h0;
      rsel <= dma_addr[3:2];
      if (wr && !busy && dma_addr[3:2] == dma_src_off) src <= {dma_wdata[31:2], 2'b00};
      if (wr && !busy && dma_addr[3:2] == dma_dst_off) dst <= {dma_wdata[31:2], 2'b00};
      if (wr && !busy && dma_addr[3:2] == dma_len_off) len <= dma_wdata;
      if (wr && dma_addr[3:2] == dma_ctrl_off && dma_wdata[ctrl_done]) done <= 1'b0;
`ifdef DMA_IRQ_EN
      if (wr && dma_addr[3:2] == dma_ctrl_off) irq_en <= dma_wdata[ctrl_irq_en];
`endif
      if (complete) done <= 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cur_src <= '0;
      cur_dst <= '0;
      remaining <= '0;
      data <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        cur_src <= src;
        cur_dst <= dst;
        remaining <= len;
      end
      if (state == RD_WAIT && dmem_ready) data <= dmem_rdata;
      if (state == WR_WAIT && dmem_ready) begin
        cur_src <= cur_src + 32'd4;
        cur_dst <= cur_dst + 32'd4;
        remaining <= remaining - 32'd1;
      end
    end
  end
  always_comb begin
    state_n = state == IDLE    ? (start && len != '0 ? RD_REQ : IDLE)
            : state == RD_REQ  ? RD_WAIT
            : state == RD_WAIT ? (dmem_ready ? WR_REQ : RD_WAIT)
            : state == WR_REQ  ? WR_WAIT
            : dmem_ready       ? (remaining == 32'd1 ? IDLE : RD_REQ)
            : WR_WAIT;
  end
  always_comb begin
    dmem_valid = state == RD_REQ || state == WR_REQ;
    dmem_instr = 1'b0;
    dmem_addr = state == RD_REQ ? cur_src : state == WR_REQ ? cur_dst : '0;
    dmem_wdata = state == WR_REQ ? data : '0;
    dmem_wstrb = state == WR_REQ ? 4'hf : 4'h0;
    dma_ready = ack;
    dma_rdata = !rd                  ? '0
              : rsel == dma_src_off  ? src
              : rsel == dma_dst_off  ? dst
              : rsel == dma_len_off  ? len
              : {28'd0, irq_en, done, busy, 1'b0};
`ifdef DMA_IRQ_EN
    dma_irq = done & irq_en;
`else
    dma_irq = 1'b0;
`endif
  end
endmodule

// File: tb/tb_dma.sv
// tb_dma: scoreboard bench for dma; a negedge-driven RAM responder checks every master request in order
module tb_dma;
  logic clock = 0, reset = 1, dma_valid = 0, dma_instr = 0;
  logic [31:0] dma_addr = 0, dma_wdata = 0;
  logic [3:0] dma_wstrb = 0;
  logic [31:0] dma_rdata, dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = 0;
  logic dma_ready, dmem_valid, dmem_instr, dma_irq;
  logic dmem_ready = 0;
  logic [3:0] dmem_wstrb;
  localparam logic [31:0] A_SRC = 0, A_DST = 4, A_LEN = 8, A_CTRL = 12;
`ifdef DMA_IRQ_EN
  localparam bit IRQ = 1;
`else
  localparam bit IRQ = 0;
`endif
  typedef struct {logic [31:0] addr; logic [31:0] data; logic we; int t;} txn_t;
  txn_t exp_q[$];
  logic [31:0] mem [0:1023];
  int vectors = 0, errors = 0, cyc = 0, wait_n = 0, cnt = 0, nvalid = 0, viol = 0;
  bit pend = 0;
  logic [31:0] p_addr = 0, p_wdata = 0;
  logic p_we = 0;

  dma dut (.clock(clock), .reset(reset), .dma_valid(dma_valid), .dma_instr(dma_instr),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb), .dma_rdata(dma_rdata),
    .dma_ready(dma_ready), .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .dma_irq(dma_irq));

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // responder: ready arrives wait_n+1 cycles after the request; expected requests are popped here
  always @(negedge clock) begin
    txn_t e;
    dmem_ready = 0;
    dmem_rdata = 0;
    if (pend) begin
      if (cnt == 0) begin
        dmem_ready = 1;
        dmem_rdata = mem[p_addr[11:2]];
        if (p_we) mem[p_addr[11:2]] = p_wdata;
        pend = 0;
      end else cnt--;
    end
    if (dmem_valid) begin
      nvalid++;
      if (pend || dmem_instr !== 1'b0) viol++;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req: addr=%h wstrb=%h cyc=%0d, no request expected", dmem_addr, dmem_wstrb, cyc);
      end else begin
        e = exp_q.pop_front();
        if (dmem_addr !== e.addr || dmem_wstrb !== (e.we ? 4'hf : 4'h0) || (e.we && dmem_wdata !== e.data) || cyc !== e.t) begin
          errors++;
          $display("FAIL master_req: got addr=%h wstrb=%h wdata=%h cyc=%0d, want addr=%h we=%0d wdata=%h cyc=%0d",
            dmem_addr, dmem_wstrb, dmem_wdata, cyc, e.addr, e.we, e.data, e.t);
        end
      end
      pend = 1;
      cnt = wait_n;
      p_addr = dmem_addr;
      p_wdata = dmem_wdata;
      p_we = dmem_wstrb == 4'hf;
    end else if (dmem_addr !== 0 || dmem_wdata !== 0 || dmem_wstrb !== 0) viol++;
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic we, input int t);
    exp_q.push_back('{a, d, we, t});
  endtask

  task automatic reg_rw(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, output logic [31:0] r);
    dma_valid = 1; dma_addr = a; dma_wdata = wd; dma_wstrb = ws;
    @(negedge clock);
    dma_valid = 0; dma_addr = 0; dma_wdata = 0; dma_wstrb = 0;
    vectors++;
    if (dma_ready !== 1'b1) begin
      errors++;
      $display("FAIL reg_ready: addr=%h got %b want 1", a, dma_ready);
    end
    r = dma_rdata;
    @(negedge clock);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    reset = 1;
    repeat (3) @(negedge clock);
    vectors++;
    if ({dma_ready, dma_rdata, dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb, dma_irq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rdata=%h valid=%b addr=%h wdata=%h wstrb=%h irq=%b, want all 0",
        dma_ready, dma_rdata, dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb, dma_irq);
    end
    reset = 0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      reg_rw(i * 4, 0, 0, r);
      vectors++;
      if (r !== 0) begin errors++; $display("FAIL reset_reg%0d: got %h want 0", i, r); end
    end
  endtask

  task automatic test_copy;
    logic [31:0] r;
    int t0;
    wait_n = 0;
    mem[64] = 32'hAAAA_0001; mem[65] = 32'hBBBB_0002; mem[66] = 32'hCCCC_0003;
    reg_rw(A_SRC, 32'h100, 4'hf, r);
    reg_rw(A_DST, 32'h200, 4'hf, r);
    reg_rw(A_LEN, 3, 4'hf, r);
    t0 = cyc + 1;
    push(32'h100, 0, 0, t0); push(32'h200, 32'hAAAA_0001, 1, t0 + 2);
    push(32'h104, 0, 0, t0 + 4); push(32'h204, 32'hBBBB_0002, 1, t0 + 6);
    push(32'h108, 0, 0, t0 + 8); push(32'h208, 32'hCCCC_0003, 1, t0 + 10);
    reg_rw(A_CTRL, 1, 4'hf, r);
    while (cyc < t0 + 10) @(negedge clock);
    reg_rw(A_CTRL, 0, 0, r);
    vectors++;
    if (r !== 32'h2) begin errors++; $display("FAIL copy_busy_cycle11: got %h want 2", r); end
    reg_rw(A_CTRL, 0, 0, r);
    vectors++;
    if (r !== 32'h4) begin errors++; $display("FAIL copy_done_cycle12: got %h want 4", r); end
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL copy_missing_reqs: %0d left want 0", exp_q.size()); end
    vectors++;
    if (mem[128] !== 32'hAAAA_0001 || mem[129] !== 32'hBBBB_0002 || mem[130] !== 32'hCCCC_0003) begin
      errors++;
      $display("FAIL copy_dest: got %h %h %h", mem[128], mem[129], mem[130]);
    end
    reg_rw(A_SRC, 0, 0, r);
    vectors++;
    if (r !== 32'h100) begin errors++; $display("FAIL copy_src_kept: got %h want 100", r); end
    reg_rw(A_DST, 0, 0, r);
    vectors++;
    if (r !== 32'h200) begin errors++; $display("FAIL copy_dst_kept: got %h want 200", r); end
    reg_rw(A_LEN, 0, 0, r);
    vectors++;
    if (r !== 3) begin errors++; $display("FAIL copy_len_kept: got %h want 3", r); end
    reg_rw(A_CTRL, 4, 4'hf, r);
    reg_rw(A_CTRL, 0, 0, r);
    vectors++;
    if (r !== 0) begin errors++; $display("FAIL done_clear: got %h want 0", r); end
  endtask

  task automatic test_len0_irq;
    logic [31:0] r;
    int nv;
    reg_rw(A_LEN, 0, 4'hf, r);
    nv = nvalid;
    reg_rw(A_CTRL, 9, 4'hf, r);
    reg_rw(A_CTRL, 0, 0, r);
    vectors++;
    if (r !== (IRQ ? 32'hC : 32'h4)) begin errors++; $display("FAIL len0_ctrl: got %h want %h", r, IRQ ? 32'hC : 32'h4); end
    vectors++;
    if (dma_irq !== IRQ) begin errors++; $display("FAIL len0_irq: got %b want %b", dma_irq, IRQ); end
    vectors++;
    if (nvalid != nv) begin errors++; $display("FAIL len0_no_req: got %0d requests want 0", nvalid - nv); end
    reg_rw(A_CTRL, 4, 4'hf, r);
    reg_rw(A_CTRL, 0, 0, r);
    vectors++;
    if (r !== 0 || dma_irq !== 1'b0) begin errors++; $display("FAIL len0_clear: got ctrl=%h irq=%b want 0 0", r, dma_irq); end
  endtask

  task automatic test_wait_states;
    logic [31:0] r;
    int t0;
    wait_n = 3;
    mem[192] = 32'hDDDD_0004;
    reg_rw(A_SRC, 32'h300, 4'hf, r);
    reg_rw(A_DST, 32'h400, 4'hf, r);
    reg_rw(A_LEN, 1, 4'hf, r);
    t0 = cyc + 1;
    push(32'h300, 0, 0, t0); push(32'h400, 32'hDDDD_0004, 1, t0 + 5);
    reg_rw(A_CTRL, 1, 4'hf, r);
    while (cyc < t0 + 8) @(negedge clock);
    reg_rw(A_CTRL, 0, 0, r);
    vectors++;
    if (r !== 32'h2) begin errors++; $display("FAIL wait_busy_cycle9: got %h want 2", r); end
    reg_rw(A_CTRL, 0, 0, r);
    vectors++;
    if (r !== 32'h4) begin errors++; $display("FAIL wait_done_cycle10: got %h want 4", r); end
    vectors++;
    if (mem[256] !== 32'hDDDD_0004 || exp_q.size() != 0 || viol != 0) begin
      errors++;
      $display("FAIL wait_result: dest=%h left=%0d viol=%0d want dddd0004 0 0", mem[256], exp_q.size(), viol);
    end
    reg_rw(A_CTRL, 4, 4'hf, r);
    wait_n = 0;
  endtask

  task automatic test_wrap;
    logic [31:0] r;
    int t0;
    mem[1023] = 32'hEEEE_0005; mem[0] = 32'hFFFF_0006;
    reg_rw(A_SRC, 32'hFFFF_FFFC, 4'hf, r);
    reg_rw(A_DST, 32'h500, 4'hf, r);
    reg_rw(A_LEN, 2, 4'hf, r);
    t0 = cyc + 1;
    push(32'hFFFF_FFFC, 0, 0, t0); push(32'h500, 32'hEEEE_0005, 1, t0 + 2);
    push(32'h0, 0, 0, t0 + 4); push(32'h504, 32'hFFFF_0006, 1, t0 + 6);
    reg_rw(A_CTRL, 1, 4'hf, r);
    r = 0;
    for (int i = 0; i < 30 && r[2] !== 1'b1; i++) reg_rw(A_CTRL, 0, 0, r);
    vectors++;
    if (r !== 32'h4 || exp_q.size() != 0) begin errors++; $display("FAIL wrap_done: ctrl=%h left=%0d want 4 0", r, exp_q.size()); end
    vectors++;
    if (mem[320] !== 32'hEEEE_0005 || mem[321] !== 32'hFFFF_0006) begin
      errors++;
      $display("FAIL wrap_dest: got %h %h", mem[320], mem[321]);
    end
  endtask

  task automatic test_done_collision;
    logic [31:0] r;
    int t0;
    mem[384] = 32'h1234_5678;
    reg_rw(A_SRC, 32'h600, 4'hf, r);
    reg_rw(A_DST, 32'h700, 4'hf, r);
    reg_rw(A_LEN, 1, 4'hf, r);
    t0 = cyc + 1;
    push(32'h600, 0, 0, t0); push(32'h700, 32'h1234_5678, 1, t0 + 2);
    reg_rw(A_CTRL, 1, 4'hf, r);
    while (cyc < t0 + 3) @(negedge clock);
    reg_rw(A_CTRL, 4, 4'hf, r);
    reg_rw(A_CTRL, 0, 0, r);
    vectors++;
    if (r !== 32'h4 || exp_q.size() != 0) begin errors++; $display("FAIL clear_vs_complete: ctrl=%h left=%0d want 4 0", r, exp_q.size()); end
    reg_rw(A_CTRL, 4, 4'hf, r);
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    int t0;
    mem[512] = 32'h0BAD_F00D; mem[513] = 32'hCAFE_BABE;
    reg_rw(A_SRC, 32'h800, 4'hf, r);
    reg_rw(A_DST, 32'h880, 4'hf, r);
    reg_rw(A_LEN, 2, 4'hf, r);
    for (int run = 0; run < 2; run++) begin
      t0 = cyc + 1;
      push(32'h800, 0, 0, t0); push(32'h880, 32'h0BAD_F00D, 1, t0 + 2);
      push(32'h804, 0, 0, t0 + 4); push(32'h884, 32'hCAFE_BABE, 1, t0 + 6);
      reg_rw(A_CTRL, 1, 4'hf, r);
      reg_rw(A_SRC, 32'h999, 4'hf, r);
      reg_rw(A_LEN, 5, 4'hf, r);
      reg_rw(A_CTRL, 1, 4'hf, r);
      r = 0;
      for (int i = 0; i < 30 && r[2] !== 1'b1; i++) reg_rw(A_CTRL, 0, 0, r);
      vectors++;
      if (r !== 32'h4 || exp_q.size() != 0) begin errors++; $display("FAIL busy_run%0d: ctrl=%h left=%0d want 4 0", run, r, exp_q.size()); end
      reg_rw(A_SRC, 0, 0, r);
      vectors++;
      if (r !== 32'h800) begin errors++; $display("FAIL busy_src_ignored%0d: got %h want 800", run, r); end
      reg_rw(A_LEN, 0, 0, r);
      vectors++;
      if (r !== 2) begin errors++; $display("FAIL busy_len_ignored%0d: got %h want 2", run, r); end
      reg_rw(A_CTRL, 4, 4'hf, r);
    end
    reg_rw(A_SRC, 32'h103, 4'hf, r);
    reg_rw(A_SRC, 0, 0, r);
    vectors++;
    if (r !== 32'h100) begin errors++; $display("FAIL src_align: got %h want 100", r); end
    reg_rw(A_SRC, 32'h5554, 4'h3, r);
    reg_rw(A_SRC, 0, 0, r);
    vectors++;
    if (r !== 32'h100) begin errors++; $display("FAIL partial_strobe: got %h want 100", r); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    int t0, nv;
    wait_n = 3;
    mem[576] = 32'h5A5A_A5A5;
    reg_rw(A_SRC, 32'h900, 4'hf, r);
    reg_rw(A_DST, 32'h980, 4'hf, r);
    reg_rw(A_LEN, 1, 4'hf, r);
    t0 = cyc + 1;
    push(32'h900, 0, 0, t0); push(32'h980, 32'h5A5A_A5A5, 1, t0 + 5);
    reg_rw(A_CTRL, 9, 4'hf, r);
    while (cyc < t0 + 7) @(negedge clock);
    reset = 1;
    @(negedge clock);
    vectors++;
    if (dmem_valid !== 1'b0 || dma_irq !== 1'b0) begin errors++; $display("FAIL reset_mid_out: valid=%b irq=%b want 0 0", dmem_valid, dma_irq); end
    reset = 0;
    nv = nvalid;
    repeat (5) @(negedge clock);
    vectors++;
    if (nvalid != nv || dma_irq !== 1'b0) begin errors++; $display("FAIL reset_mid_quiet: reqs=%0d irq=%b want 0 0", nvalid - nv, dma_irq); end
    reg_rw(A_CTRL, 0, 0, r);
    vectors++;
    if (r !== 0) begin errors++; $display("FAIL reset_mid_ctrl: got %h want 0", r); end
    reg_rw(A_SRC, 0, 0, r);
    vectors++;
    if (r !== 0 || exp_q.size() != 0 || viol != 0) begin
      errors++;
      $display("FAIL reset_mid_state: src=%h left=%0d viol=%0d want 0 0 0", r, exp_q.size(), viol);
    end
    wait_n = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 0;
    @(negedge clock);
    test_reset();
    test_copy();
    test_len0_irq();
    test_wait_states();
    test_wrap();
    test_done_collision();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
